register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Clocked, parametrised register file with two read ports (x, y) and two write ports (z, w).
- Adds a per-register lock scoreboard. A read that targets a locked register waits until that register is written, then returns the new value.
- Sits between the instruction decoder/ALU and memory unit. It replaces the enable-edge-triggered register bank with one synchronous design.

Parameters:
- W, 8, data width in bits
- SEL_W, 4, select width
- N, 1<<SEL_W, number of registers (must be <= 2^SEL_W)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and locks

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- x_enb  in  1  read request, port x
- x_sel  in  SEL_W  register index, port x
- x_out  out  W  read data, port x
- x_valid  out  1  one-cycle pulse: x_out holds the requested data
- x_busy  out  1  port x is waiting on a locked register
- y_enb, y_sel, y_out, y_valid, y_busy: identical to port x
- z_enb  in  1  write enable, primary write port
- z_sel  in  SEL_W  write index
- z_in  in  W  write data
- w_enb, w_sel, w_in: secondary write port, same widths
- lk_enb  in  1  set lock on register lk_sel
- lk_sel  in  SEL_W  register to lock
- locks  out  N  current lock bitmask

Behaviour:
- Reset (reset=0, async): all registers and locks = 0; x_out = y_out = 0; x_valid = y_valid = 0; x_busy = y_busy = 0; both read ports go to IDLE. Reset mid-wait abandons the pending read, with no valid pulse.
- Writes: take effect at the rising edge.
  - z_enb and w_enb to the same index in the same cycle: z wins.
  - A write clears that register's lock bit.
  - Index >= N: write ignored.
  - ZERO_REG=1 and index 0: write ignored.
- Locks:
  - lk_enb sets locks[lk_sel] at the edge.
  - Lock and write to the same register in the same cycle: the data is written and the lock ends set (lock wins).
  - Lock on register 0 with ZERO_REG=1, or index >= N: ignored.
- Read port FSM (x and y independent, identical):
  - IDLE, x_enb=1, target unlocked (or being written this cycle): next edge sets x_out and pulses x_valid=1. Latency 1 cycle. Data is forwarded: a same-cycle write (z over w) to the target supplies the new data.
  - IDLE, x_enb=1, target locked and not being written this cycle: capture x_sel, go to WAIT. x_busy=1 from the next cycle; x_valid=0.
  - WAIT: x_enb is ignored. In the cycle a write to the captured index occurs, the next edge sets x_out to the forwarded write data, pulses x_valid=1 and returns to IDLE (x_busy=0). If the lock is re-set in that same cycle, the read still completes with the written data.
  - A lock set in the same cycle as a read request does not affect that request. The read sees pre-edge lock state.
  - x_out holds its last value when not updated. x_valid is high for exactly one cycle per completed read.
  - Index >= N reads 0 and never waits. ZERO_REG=1 and index 0 reads 0 and never waits.
- Back-to-back reads in consecutive cycles in IDLE: one result per cycle.
- Register contents are never visible other than through read ports and locks.

Test Plan:
- Reset then read: write z: r3=0x5A; next cycle x_enb, x_sel=3 -> following cycle x_out=0x5A, x_valid=1 for one cycle. Read r7 after reset -> x_out=0x00.
- Forward and collision: same cycle z_enb r2=0x11, w_enb r2=0x22, y_enb y_sel=2 -> y_out=0x11; later read of r2 -> 0x11.
- Lock/wait: lk_enb r5. Next cycle x_enb r5 -> x_busy=1, x_valid=0 for 4 cycles. Then w writes r5=0xC3 -> next cycle x_out=0xC3, x_valid=1, x_busy=0, locks[5]=0.
- Zero register: z writes r0=0xFF, lk_enb r0, x reads r0 -> x_out=0x00, no wait, locks=0.
- Lock+write same cycle: z writes r4=0x77 with lk_enb r4 -> locks[4]=1; y read r4 waits; a later z write r4=0x78 -> y_out=0x78.
- Async reset mid-wait: x in WAIT on r6; assert reset between edges -> x_busy, x_valid, x_out, locks go to 0 immediately. After release, read r6 -> 0x00.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with two read ports (x, y),
// two write ports (z primary, w secondary) and a per-register lock scoreboard.
// A read that targets a locked register parks in a wait state until that
// register is written, then returns the written value.
module register_file_sb #(
  parameter int W        = 8,
  parameter int SEL_W    = 4,
  parameter int N        = 1 << SEL_W,
  parameter int ZERO_REG = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_enb,
  input  logic [SEL_W-1:0] x_sel,
  output logic [W-1:0]     x_out,
  output logic             x_valid,
  output logic             x_busy,
  input  logic             y_enb,
  input  logic [SEL_W-1:0] y_sel,
  output logic [W-1:0]     y_out,
  output logic             y_valid,
  output logic             y_busy,
  input  logic             z_enb,
  input  logic [SEL_W-1:0] z_sel,
  input  logic [W-1:0]     z_in,
  input  logic             w_enb,
  input  logic [SEL_W-1:0] w_sel,
  input  logic [W-1:0]     w_in,
  input  logic             lk_enb,
  input  logic [SEL_W-1:0] lk_sel,
  output logic [N-1:0]     locks
);

  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;

  logic [W-1:0]     regs [N];
  logic [N-1:0]     lock_q;

  // Read-port state, index 0 = port x, index 1 = port y
  rd_state_t        st_q   [2];
  rd_state_t        st_d   [2];
  logic [SEL_W-1:0] cap_q  [2];
  logic [SEL_W-1:0] cap_d  [2];
  logic [W-1:0]     out_q  [2];
  logic [W-1:0]     out_d  [2];
  logic [1:0]       valid_q, valid_d;
  logic [1:0]       busy_q, busy_d;

  logic [1:0]       rd_enb;
  logic [SEL_W-1:0] rd_sel [2];

  logic             z_ok, w_ok, lk_ok;

  // Index is a real, writable/lockable register
  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return (32'(s) < N) && !(ZERO_REG != 0 && s == '0);
  endfunction

  function automatic logic sel_is(input logic [SEL_W-1:0] s, input int unsigned i);
    return 32'(s) == i;
  endfunction

  // Register contents for an index; out-of-range indices read as zero
  function automatic logic [W-1:0] reg_at(input logic [SEL_W-1:0] s);
    logic [W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_is(s, i)) v = regs[i];
    end
    return v;
  endfunction

  assign rd_enb    = {y_enb, x_enb};
  assign rd_sel[0] = x_sel;
  assign rd_sel[1] = y_sel;

  assign z_ok  = z_enb  && sel_ok(z_sel);
  assign w_ok  = w_enb  && sel_ok(w_sel);
  assign lk_ok = lk_enb && sel_ok(lk_sel);

  // Read-port next-state: immediate read with write forwarding, or park on a lock
  always_comb begin
    logic [SEL_W-1:0] tgt;
    logic             z_hit;
    logic             w_hit;
    logic [W-1:0]     fwd;
    for (int unsigned p = 0; p < 2; p++) begin
      st_d[p]    = st_q[p];
      cap_d[p]   = cap_q[p];
      out_d[p]   = out_q[p];
      valid_d[p] = 1'b0;
      tgt        = (st_q[p] == RD_IDLE) ? rd_sel[p] : cap_q[p];
      z_hit      = z_ok && (z_sel == tgt);
      w_hit      = w_ok && (w_sel == tgt);
      fwd        = z_hit ? z_in : (w_hit ? w_in : reg_at(tgt));
      case (st_q[p])
        RD_IDLE: begin
          if (rd_enb[p]) begin
            if (!sel_ok(tgt)) begin
              out_d[p]   = '0;
              valid_d[p] = 1'b1;
            end else if (!lock_q[32'(tgt)] || z_hit || w_hit) begin
              out_d[p]   = fwd;
              valid_d[p] = 1'b1;
            end else begin
              st_d[p]  = RD_WAIT;
              cap_d[p] = tgt;
            end
          end
        end
        RD_WAIT: begin
          if (z_hit || w_hit) begin
            out_d[p]   = fwd;
            valid_d[p] = 1'b1;
            st_d[p]    = RD_IDLE;
          end
        end
        default: st_d[p] = RD_IDLE;
      endcase
      busy_d[p] = (st_d[p] == RD_WAIT);
    end
  end

  // Read-port state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        st_q[p]  <= RD_IDLE;
        cap_q[p] <= '0;
        out_q[p] <= '0;
      end
      valid_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        st_q[p]  <= st_d[p];
        cap_q[p] <= cap_d[p];
        out_q[p] <= out_d[p];
      end
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Register writes (z overrides w) and lock scoreboard (set overrides clear)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) regs[i] <= '0;
      lock_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_ok && sel_is(w_sel, i)) regs[i] <= w_in;
        if (z_ok && sel_is(z_sel, i)) regs[i] <= z_in;
        if ((w_ok && sel_is(w_sel, i)) || (z_ok && sel_is(z_sel, i))) lock_q[i] <= 1'b0;
        if (lk_ok && sel_is(lk_sel, i)) lock_q[i] <= 1'b1;
      end
    end
  end

  assign x_out   = out_q[0];
  assign x_valid = valid_q[0];
  assign x_busy  = busy_q[0];
  assign y_out   = out_q[1];
  assign y_valid = valid_q[1];
  assign y_busy  = busy_q[1];
  assign locks   = lock_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_register_file_sb;

  localparam int TW   = 8;
  localparam int TSEL = 4;
  localparam int TN   = 12;
  localparam int TZ   = 1;

  logic            clock;
  logic            reset;
  logic            x_enb, y_enb, z_enb, w_enb, lk_enb;
  logic [TSEL-1:0] x_sel, y_sel, z_sel, w_sel, lk_sel;
  logic [TW-1:0]   z_in, w_in;
  logic [TW-1:0]   x_out, y_out;
  logic            x_valid, x_busy, y_valid, y_busy;
  logic [TN-1:0]   locks;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  register_file_sb #(.W(TW), .SEL_W(TSEL), .N(TN), .ZERO_REG(TZ)) dut (
    .clock(clock), .reset(reset),
    .x_enb(x_enb), .x_sel(x_sel), .x_out(x_out), .x_valid(x_valid), .x_busy(x_busy),
    .y_enb(y_enb), .y_sel(y_sel), .y_out(y_out), .y_valid(y_valid), .y_busy(y_busy),
    .z_enb(z_enb), .z_sel(z_sel), .z_in(z_in),
    .w_enb(w_enb), .w_sel(w_sel), .w_in(w_in),
    .lk_enb(lk_enb), .lk_sel(lk_sel), .locks(locks)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [TW-1:0] m_mem [TN];
  bit            m_lk  [TN];
  bit            m_wait [2];
  int            m_wsel [2];
  logic [TW-1:0] m_out  [2];
  bit            m_valid[2];

  function automatic bit m_ok(int s);
    return (s < TN) && !(TZ != 0 && s == 0);
  endfunction

  function automatic bit m_hit(int s);
    return (z_enb && m_ok(int'(z_sel)) && int'(z_sel) == s) ||
           (w_enb && m_ok(int'(w_sel)) && int'(w_sel) == s);
  endfunction

  function automatic logic [TW-1:0] m_fwd(int s);
    if (z_enb && m_ok(int'(z_sel)) && int'(z_sel) == s) return z_in;
    if (w_enb && m_ok(int'(w_sel)) && int'(w_sel) == s) return w_in;
    return m_mem[s];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TN; i++) begin m_mem[i] = '0; m_lk[i] = 0; end
      for (int p = 0; p < 2; p++) begin
        m_wait[p] = 0; m_wsel[p] = 0; m_out[p] = '0; m_valid[p] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        bit en;
        int s;
        en = (p == 0) ? x_enb : y_enb;
        s  = (p == 0) ? int'(x_sel) : int'(y_sel);
        m_valid[p] = 0;
        if (m_wait[p]) begin
          if (m_hit(m_wsel[p])) begin
            m_out[p] = m_fwd(m_wsel[p]); m_valid[p] = 1; m_wait[p] = 0;
          end
        end else if (en) begin
          if (!m_ok(s)) begin
            m_out[p] = '0; m_valid[p] = 1;
          end else if (!m_lk[s] || m_hit(s)) begin
            m_out[p] = m_fwd(s); m_valid[p] = 1;
          end else begin
            m_wait[p] = 1; m_wsel[p] = s;
          end
        end
      end
      if (w_enb && m_ok(int'(w_sel))) begin m_mem[w_sel] = w_in; m_lk[w_sel] = 0; end
      if (z_enb && m_ok(int'(z_sel))) begin m_mem[z_sel] = z_in; m_lk[z_sel] = 0; end
      if (lk_enb && m_ok(int'(lk_sel))) m_lk[lk_sel] = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (check_en && reset) begin
      logic [TN-1:0] e;
      for (int i = 0; i < TN; i++) e[i] = m_lk[i];
      chk("x_out",   32'(x_out),   32'(m_out[0]));
      chk("x_valid", 32'(x_valid), 32'(m_valid[0]));
      chk("x_busy",  32'(x_busy),  32'(m_wait[0]));
      chk("y_out",   32'(y_out),   32'(m_out[1]));
      chk("y_valid", 32'(y_valid), 32'(m_valid[1]));
      chk("y_busy",  32'(y_busy),  32'(m_wait[1]));
      chk("locks",   32'(locks),   32'(e));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    x_enb = 0; y_enb = 0; z_enb = 0; w_enb = 0; lk_enb = 0;
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  initial begin
    reset = 0;
    idle();
    x_sel = '0; y_sel = '0; z_sel = '0; w_sel = '0; lk_sel = '0;
    z_in = '0; w_in = '0;
    repeat (2) nxt();
    chk("rst_x_out", 32'(x_out), 32'h0);
    chk("rst_x_valid", 32'(x_valid), 32'h0);
    chk("rst_y_busy", 32'(y_busy), 32'h0);
    chk("rst_locks", 32'(locks), 32'h0);
    reset = 1;
    check_en = 1;
    nxt();

    // write then read, and read of an untouched register
    z_enb = 1; z_sel = 3; z_in = 8'h5A;
    nxt(); idle();
    x_enb = 1; x_sel = 3;
    nxt();
    chk("t1_x_out", 32'(x_out), 32'h5A);
    chk("t1_x_valid", 32'(x_valid), 32'h1);
    x_sel = 7;
    nxt();
    chk("t1_r7", 32'(x_out), 32'h00);
    idle();
    nxt();
    chk("t1_pulse_end", 32'(x_valid), 32'h0);

    // write collision with forwarding
    z_enb = 1; z_sel = 2; z_in = 8'h11;
    w_enb = 1; w_sel = 2; w_in = 8'h22;
    y_enb = 1; y_sel = 2;
    nxt(); idle();
    chk("t2_fwd", 32'(y_out), 32'h11);
    x_enb = 1; x_sel = 2;
    nxt(); idle();
    chk("t2_later", 32'(x_out), 32'h11);

    // lock then wait for a write
    lk_enb = 1; lk_sel = 5;
    nxt(); idle();
    x_enb = 1; x_sel = 5;
    nxt(); idle();
    for (int i = 0; i < 4; i++) begin
      chk("t3_busy", 32'(x_busy), 32'h1);
      chk("t3_novalid", 32'(x_valid), 32'h0);
      chk("t3_hold", 32'(x_out), 32'h11);
      if (i == 3) begin w_enb = 1; w_sel = 5; w_in = 8'hC3; end
      nxt();
    end
    idle();
    chk("t3_data", 32'(x_out), 32'hC3);
    chk("t3_valid", 32'(x_valid), 32'h1);
    chk("t3_busy_end", 32'(x_busy), 32'h0);
    chk("t3_unlock", 32'(locks[5]), 32'h0);

    // zero register
    z_enb = 1; z_sel = 0; z_in = 8'hFF;
    lk_enb = 1; lk_sel = 0;
    x_enb = 1; x_sel = 0;
    nxt(); idle();
    chk("t4_zero", 32'(x_out), 32'h00);
    chk("t4_valid", 32'(x_valid), 32'h1);
    chk("t4_nolock", 32'(locks), 32'h0);

    // lock and write same cycle
    z_enb = 1; z_sel = 4; z_in = 8'h77;
    lk_enb = 1; lk_sel = 4;
    nxt(); idle();
    chk("t5_lock", 32'(locks[4]), 32'h1);
    y_enb = 1; y_sel = 4;
    nxt(); idle();
    chk("t5_wait", 32'(y_busy), 32'h1);
    z_enb = 1; z_sel = 4; z_in = 8'h78;
    nxt(); idle();
    chk("t5_data", 32'(y_out), 32'h78);
    chk("t5_valid", 32'(y_valid), 32'h1);

    // out-of-range index: writes and locks ignored, reads return 0
    z_enb = 1; z_sel = 13; z_in = 8'hAA;
    lk_enb = 1; lk_sel = 13;
    nxt(); idle();
    x_enb = 1; x_sel = 13;
    nxt(); idle();
    chk("t6_oor", 32'(x_out), 32'h00);
    chk("t6_nowait", 32'(x_busy), 32'h0);
    chk("t6_locks", 32'(locks), 32'h0);

    // async reset while waiting
    x_enb = 1; x_sel = 2;
    nxt(); idle();
    chk("t7_pre", 32'(x_out), 32'h11);
    lk_enb = 1; lk_sel = 6;
    nxt(); idle();
    x_enb = 1; x_sel = 6;
    nxt(); idle();
    chk("t7_busy", 32'(x_busy), 32'h1);
    @(posedge clock);
    #2 reset = 0;
    #1;
    chk("t7_rst_busy", 32'(x_busy), 32'h0);
    chk("t7_rst_valid", 32'(x_valid), 32'h0);
    chk("t7_rst_out", 32'(x_out), 32'h0);
    chk("t7_rst_locks", 32'(locks), 32'h0);
    @(negedge clock);
    #1 reset = 1;
    x_enb = 1; x_sel = 6;
    nxt(); idle();
    chk("t7_after", 32'(x_out), 32'h00);
    chk("t7_after_valid", 32'(x_valid), 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      x_enb  = 1'($urandom_range(0, 1));
      y_enb  = 1'($urandom_range(0, 1));
      z_enb  = 1'($urandom_range(0, 1));
      w_enb  = 1'($urandom_range(0, 1));
      lk_enb = ($urandom_range(0, 2) == 0);
      x_sel  = 4'($urandom_range(0, 15));
      y_sel  = 4'($urandom_range(0, 15));
      z_sel  = 4'($urandom_range(0, 15));
      w_sel  = 4'($urandom_range(0, 15));
      lk_sel = 4'($urandom_range(0, 15));
      z_in   = 8'($urandom);
      w_in   = 8'($urandom);
      if (n == 1500) begin
        @(posedge clock);
        #2 reset = 0;
        @(negedge clock);
        #1 reset = 1;
      end
      nxt();
    end
    idle();
    repeat (3) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
